// File: rtl/beep_pkg.sv
// ============================================================================
// Module      : beep_pkg
// Description : Shared types and default timing constants for the beep
//               pattern sequencer and its interval counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package beep_pkg;

  // Sequencer FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_ON    = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Source of the running sequence: host request or level alarm
  typedef enum logic {
    MODE_REQ   = 1'b0,
    MODE_ALARM = 1'b1
  } mode_t;

  // Driver occupancy per beep (0.25 s tone + state entry) and the silent
  // gap that follows it, both in 50 MHz clk cycles
  localparam int unsigned BEEP_ON_CYC  = 12_500_002;
  localparam int unsigned BEEP_GAP_CYC = 5_000_000;

endpackage : beep_pkg

`default_nettype wire

// File: rtl/beep_pattern_seq_if.sv
// ============================================================================
// Module      : beep_pattern_seq_if
// Description : Request / alarm / buzzer-enable signal bundle between the
//               UI trigger logic (master) and the beep sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface beep_pattern_seq_if;

  logic       req_valid;
  logic [2:0] req_count;
  logic       req_ready;
  logic       alarm_in;
  logic       beep_en;
  logic       busy;

  // Trigger logic side
  modport master (
    output req_valid,
    output req_count,
    output alarm_in,
    input  req_ready,
    input  beep_en,
    input  busy
  );

  // Sequencer side
  modport slave (
    input  req_valid,
    input  req_count,
    input  alarm_in,
    output req_ready,
    output beep_en,
    output busy
  );

endinterface : beep_pattern_seq_if

`default_nettype wire

// File: rtl/beep_interval_cnt.sv
// ============================================================================
// Module      : beep_interval_cnt
// Description : Loadable terminal-count counter. Clears on load, counts up
//               and holds once it equals target; done is combinational.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beep_interval_cnt #(
  parameter int CNT_W = 25
) (
  input  wire logic             clk,
  input  wire logic             rstn,
  input  wire logic             load,
  input  wire logic [CNT_W-1:0] target,
  output logic                  done
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Holding at target means the counter can never wrap
  assign done = (r_cnt == target);

  // Interval count: clear on phase change, advance until target is reached
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= '0;
    end else if (!done) begin
      r_cnt <= r_cnt + c_one;
    end
  end

endmodule : beep_interval_cnt

`default_nettype wire

// File: rtl/beep_pattern_seq.sv
// ============================================================================
// Module      : beep_pattern_seq
// Description : Turns beep requests (N beeps) and a level alarm into spaced
//               one-cycle beep_en pulses for the buzzer driver.
//               Optional build macro BEEP_QUEUE_EN adds a one-entry pending
//               request buffer so requests can be accepted while busy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beep_pattern_seq
  import beep_pkg::*;
#(
  parameter int unsigned ON_CYCLES        = BEEP_ON_CYC,
  parameter int unsigned GAP_CYCLES       = BEEP_GAP_CYC,
  parameter int unsigned ALARM_GAP_CYCLES = 25_000_000,
  parameter int          CNT_W            = 25
) (
  input wire logic           clk,
  input wire logic           rstn,
  beep_pattern_seq_if.slave  bus
);

  // Counter starts at 0 on entry to each phase, so the terminal value is the
  // phase length minus one. PULSE already supplies one driver-busy cycle,
  // leaving ON_CYCLES-1 cycles for the ON phase.
  localparam logic [CNT_W-1:0] c_on_tgt   = CNT_W'(ON_CYCLES - 2);
  localparam logic [CNT_W-1:0] c_gap_tgt  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_agap_tgt = CNT_W'(ALARM_GAP_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  mode_t            r_mode, w_mode_nxt;
  logic [2:0]       r_rem, w_rem_nxt;
  logic [CNT_W-1:0] w_target;
  logic             w_load;
  logic             w_done;
  logic             w_accept;

`ifdef BEEP_QUEUE_EN
  logic             r_pend_valid;
  logic [2:0]       r_pend_count;
`endif

  assign w_accept = bus.req_valid && bus.req_ready;

  // Single interval counter shared by the ON and GAP phases
  beep_interval_cnt #(
    .CNT_W (CNT_W)
  ) u_interval_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .load   (w_load),
    .target (w_target),
    .done   (w_done)
  );

  // State, mode and remaining-beep registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_REQ;
      r_rem   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  // Next-state, phase target and counter clear on every state change
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_rem_nxt   = r_rem;
    w_target    = '0;
    case (r_state)
      ST_IDLE: begin
`ifdef BEEP_QUEUE_EN
        if (r_pend_valid) begin
          w_state_nxt = ST_PULSE;
          w_mode_nxt  = MODE_REQ;
          w_rem_nxt   = r_pend_count;
        end else
`endif
        if (w_accept && (bus.req_count != 3'd0)) begin
          w_state_nxt = ST_PULSE;
          w_mode_nxt  = MODE_REQ;
          w_rem_nxt   = bus.req_count;
        end else if (bus.alarm_in) begin
          w_state_nxt = ST_PULSE;
          w_mode_nxt  = MODE_ALARM;
          w_rem_nxt   = 3'd1;
        end
      end
      ST_PULSE: begin
        w_state_nxt = ST_ON;
        w_rem_nxt   = r_rem - 3'd1;
      end
      ST_ON: begin
        w_target = c_on_tgt;
        if (w_done) begin
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        w_target = (r_mode == MODE_ALARM) ? c_agap_tgt : c_gap_tgt;
        if (w_done) begin
          if ((r_mode == MODE_REQ) && (r_rem != 3'd0)) begin
            w_state_nxt = ST_PULSE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_load = (w_state_nxt != r_state);
  end

`ifdef BEEP_QUEUE_EN
  // Pending buffer: capture a non-zero request made while busy, release it
  // on the IDLE cycle where it is launched; zero-count requests are dropped
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_valid <= 1'b0;
      r_pend_count <= 3'd0;
    end else if ((r_state == ST_IDLE) && r_pend_valid) begin
      r_pend_valid <= 1'b0;
    end else if (w_accept && (bus.req_count != 3'd0) && (r_state != ST_IDLE)) begin
      r_pend_valid <= 1'b1;
      r_pend_count <= bus.req_count;
    end
  end

  assign bus.req_ready = rstn && !r_pend_valid;
`else
  assign bus.req_ready = rstn && (r_state == ST_IDLE);
`endif

  assign bus.beep_en = (r_state == ST_PULSE);
  assign bus.busy    = (r_state != ST_IDLE);

endmodule : beep_pattern_seq

`default_nettype wire

// File: tb/tb_beep_pattern_seq.sv
// ============================================================================
// Module      : tb_beep_pattern_seq
// Description : Scoreboard bench for beep_pattern_seq. Expected beep_en
//               cycles are queued when stimulus is applied and popped as
//               pulses appear. Covers BEEP_QUEUE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_beep_pattern_seq;

  localparam int ON   = 10;
  localparam int GAP  = 4;
  localparam int AGAP = 6;
  localparam int PER  = ON + GAP;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_q[$];
  int   t0;

  beep_pattern_seq_if bus();

  beep_pattern_seq #(
    .ON_CYCLES        (ON),
    .GAP_CYCLES       (GAP),
    .ALARM_GAP_CYCLES (AGAP),
    .CNT_W            (8)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Cycle index as seen at the following negedge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: every beep_en pulse must match the oldest expected cycle
  always @(negedge clk) begin
    if (bus.beep_en === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_pulse", cyc, -1);
      else                   check("pulse_cycle", cyc, exp_q.pop_front());
    end
  end

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic send_req(input int n);
    bus.req_valid = 1'b1;
    bus.req_count = 3'(n);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_count = 3'd0;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_count = 3'd0;
    bus.alarm_in  = 1'b0;

    // 1. Reset values, then idle
    repeat (3) @(negedge clk);
    check("rst_beep_en", int'(bus.beep_en), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_req_ready", int'(bus.req_ready), 0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_req_ready", int'(bus.req_ready), 1);
    check("idle_busy", int'(bus.busy), 0);
    check("idle_beep_en", int'(bus.beep_en), 0);

    // 2. Two-beep request
    t0 = cyc;
    check("t2_ready", int'(bus.req_ready), 1);
    exp_q.push_back(t0 + 1);
    exp_q.push_back(t0 + 1 + PER);
    send_req(2);
    check("t2_busy_first", int'(bus.busy), 1);
`ifndef BEEP_QUEUE_EN
    check("t2_ready_busy", int'(bus.req_ready), 0);
`endif
    goto(t0 + 2 * PER);
    check("t2_busy_last", int'(bus.busy), 1);
    goto(t0 + 2 * PER + 1);
    check("t2_busy_end", int'(bus.busy), 0);
    check("t2_ready_end", int'(bus.req_ready), 1);
    check("t2_missed", exp_q.size(), 0);

    // 3. Zero-count request is a no-op
    t0 = cyc;
    send_req(0);
    check("t3_busy", int'(bus.busy), 0);
    check("t3_ready", int'(bus.req_ready), 1);
    goto(t0 + 20);
    check("t3_busy_late", int'(bus.busy), 0);
    check("t3_missed", exp_q.size(), 0);

    // 4. Alarm held for 40 cycles
    t0 = cyc;
    bus.alarm_in = 1'b1;
    exp_q.push_back(t0 + 1);
    exp_q.push_back(t0 + 18);
    exp_q.push_back(t0 + 35);
    goto(t0 + 40);
    bus.alarm_in = 1'b0;
    goto(t0 + 50);
    check("t4_busy_gap", int'(bus.busy), 1);
    goto(t0 + 51);
    check("t4_busy_end", int'(bus.busy), 0);
    goto(t0 + 70);
    check("t4_missed", exp_q.size(), 0);

    // 5. Request and alarm together: request first, then alarm
    t0 = cyc;
    check("t5_ready", int'(bus.req_ready), 1);
    bus.alarm_in = 1'b1;
    exp_q.push_back(t0 + 1);
    exp_q.push_back(t0 + 1 + PER);
    exp_q.push_back(t0 + 1 + 2 * PER);
    exp_q.push_back(t0 + 44);
    send_req(3);
    goto(t0 + 45);
    bus.alarm_in = 1'b0;
    goto(t0 + 59);
    check("t5_busy_gap", int'(bus.busy), 1);
    goto(t0 + 60);
    check("t5_busy_end", int'(bus.busy), 0);
    goto(t0 + 80);
    check("t5_missed", exp_q.size(), 0);

    // 6. Reset three cycles after the first beep of a 5-beep request
    t0 = cyc;
    exp_q.push_back(t0 + 1);
    send_req(5);
    goto(t0 + 4);
    rstn = 1'b0;
    #1;
    check("t6_busy_rst", int'(bus.busy), 0);
    check("t6_beep_rst", int'(bus.beep_en), 0);
    check("t6_ready_rst", int'(bus.req_ready), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("t6_ready_after", int'(bus.req_ready), 1);
    goto(t0 + 60);
    check("t6_busy_late", int'(bus.busy), 0);
    check("t6_missed", exp_q.size(), 0);

`ifdef BEEP_QUEUE_EN
    // Queued request while busy starts on the IDLE cycle
    t0 = cyc;
    exp_q.push_back(t0 + 1);
    exp_q.push_back(t0 + 1 + PER);
    send_req(2);
    goto(t0 + 5);
    check("q_ready_busy", int'(bus.req_ready), 1);
    exp_q.push_back(t0 + 2 * PER + 2);
    send_req(1);
    check("q_ready_pending", int'(bus.req_ready), 0);
    goto(t0 + 2 * PER + 1);
    check("q_idle_busy", int'(bus.busy), 0);
    check("q_idle_ready", int'(bus.req_ready), 0);
    goto(t0 + 2 * PER + 2);
    check("q_restart_busy", int'(bus.busy), 1);
    check("q_restart_ready", int'(bus.req_ready), 1);
    goto(t0 + 60);
    check("q_missed", exp_q.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_beep_pattern_seq

`default_nettype wire
